// File: rtl/vga_box_plotter.sv
// Box plotter for the VGA adapter write port: loads X, then Y/colour, streams a BOX_W x BOX_H box or a full-screen clear.
// Optional edge clipping is enabled by defining VGA_PLOT_CLIP_EN.
module vga_box_plotter #(
    parameter int X_SCREEN_PIXELS = 160,
    parameter int Y_SCREEN_PIXELS = 120,
    parameter int BOX_W           = 4,
    parameter int BOX_H           = 4,
    parameter int COORD_W         = 7,
    parameter int COLOUR_W        = 3,
    localparam int XW             = $clog2(X_SCREEN_PIXELS),
    localparam int YW             = $clog2(Y_SCREEN_PIXELS)
) (
    input  logic                iClock,
    input  logic                iResetn,
    input  logic                iLoadX,
    input  logic                iPlotBox,
    input  logic                iBlack,
    input  logic [COORD_W-1:0]  iXY_Coord,
    input  logic [COLOUR_W-1:0] iColour,
    output logic [XW-1:0]       oX,
    output logic [YW-1:0]       oY,
    output logic [COLOUR_W-1:0] oColour,
    output logic                oPlot,
    output logic                oDone
);

    typedef enum logic [2:0] {
        S_LOAD_X,
        S_LOAD_X_WAIT,
        S_LOAD_Y,
        S_LOAD_Y_WAIT,
        S_DRAW,
        S_DONE,
        S_CLEAR
    } state_t;

    localparam logic [XW-1:0] X_LAST_BOX = XW'(BOX_W - 1);
    localparam logic [YW-1:0] Y_LAST_BOX = YW'(BOX_H - 1);
    localparam logic [XW-1:0] X_LAST_CLR = XW'(X_SCREEN_PIXELS - 1);
    localparam logic [YW-1:0] Y_LAST_CLR = YW'(Y_SCREEN_PIXELS - 1);

    // Without clipping the carry bit is never observed, so the sums stay at screen width and wrap.
`ifdef VGA_PLOT_CLIP_EN
    localparam int SX_W = XW + 1;
    localparam int SY_W = YW + 1;
`else
    localparam int SX_W = XW;
    localparam int SY_W = YW;
`endif

    state_t              state;
    logic [XW-1:0]       x_lat;
    logic [YW-1:0]       y_lat;
    logic [COLOUR_W-1:0] colour_lat;
    logic [XW-1:0]       cx;
    logic [YW-1:0]       cy;

    logic [SX_W-1:0]     sum_x;
    logic [SY_W-1:0]     sum_y;
    logic                pix_ok;
    logic                at_x_last;
    logic                at_y_last;

    assign sum_x = SX_W'(x_lat) + SX_W'(cx);
    assign sum_y = SY_W'(y_lat) + SY_W'(cy);

`ifdef VGA_PLOT_CLIP_EN
    assign pix_ok = (sum_x < SX_W'(X_SCREEN_PIXELS)) && (sum_y < SY_W'(Y_SCREEN_PIXELS));
`else
    assign pix_ok = 1'b1;
`endif

    assign at_x_last = (state == S_CLEAR) ? (cx == X_LAST_CLR) : (cx == X_LAST_BOX);
    assign at_y_last = (state == S_CLEAR) ? (cy == Y_LAST_CLR) : (cy == Y_LAST_BOX);

    always_ff @(posedge iClock or negedge iResetn) begin
        if (!iResetn) begin
            state      <= S_LOAD_X;
            x_lat      <= '0;
            y_lat      <= '0;
            colour_lat <= '0;
            cx         <= '0;
            cy         <= '0;
            oX         <= '0;
            oY         <= '0;
            oColour    <= '0;
            oPlot      <= 1'b0;
            oDone      <= 1'b0;
        end else begin
            oPlot <= 1'b0;
            oDone <= 1'b0;
            case (state)
                S_LOAD_X: begin
                    if (iBlack) begin
                        state <= S_CLEAR;
                        cx    <= '0;
                        cy    <= '0;
                    end else if (iLoadX) begin
                        state <= S_LOAD_X_WAIT;
                    end
                end
                S_LOAD_X_WAIT: begin
                    x_lat <= XW'(iXY_Coord);
                    if (!iLoadX) state <= S_LOAD_Y;
                end
                S_LOAD_Y: begin
                    if (iBlack) begin
                        state <= S_CLEAR;
                        cx    <= '0;
                        cy    <= '0;
                    end else if (iPlotBox) begin
                        state <= S_LOAD_Y_WAIT;
                    end
                end
                S_LOAD_Y_WAIT: begin
                    y_lat      <= YW'(iXY_Coord);
                    colour_lat <= iColour;
                    if (!iPlotBox) begin
                        state <= S_DRAW;
                        cx    <= '0;
                        cy    <= '0;
                    end
                end
                S_DRAW: begin
                    oX      <= sum_x[XW-1:0];
                    oY      <= sum_y[YW-1:0];
                    oColour <= colour_lat;
                    oPlot   <= pix_ok;
                    if (at_x_last && at_y_last) state <= S_DONE;
                end
                S_DONE: begin
                    if (iBlack) begin
                        state <= S_CLEAR;
                        cx    <= '0;
                        cy    <= '0;
                    end else if (iLoadX) begin
                        state <= S_LOAD_X_WAIT;
                    end else begin
                        oDone <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    oX      <= cx;
                    oY      <= cy;
                    oColour <= '0;
                    oPlot   <= 1'b1;
                    if (at_x_last && at_y_last) state <= S_DONE;
                end
                default: state <= S_LOAD_X;
            endcase

            // Raster order: cx runs fastest, cy steps when a row completes.
            if (state == S_DRAW || state == S_CLEAR) begin
                if (at_x_last) begin
                    cx <= '0;
                    cy <= cy + 1'b1;
                end else begin
                    cx <= cx + 1'b1;
                end
            end
        end
    end

endmodule
